// File: rtl/pipe_stage_reg.sv
//------------------------------------------------------------------------------
// Module   : pipe_stage_reg
// Purpose  : Valid/ready pipeline stage register with flush and a saturating
//            backpressure (stall) counter.
//            Build option PIPE_STAGE_SKID_EN:
//              defined   -> two-entry skid buffer, registered in_ready
//                           (no combinational out_ready -> in_ready path)
//              undefined -> single register, combinational in_ready
// Ports    : clk        sole clock, rising edge
//            rst        asynchronous reset, active low
//            in_valid   upstream holds a valid entry
//            in_ready   stage accepts this cycle
//            in_data    upstream payload (WIDTH)
//            out_valid  stage presents a valid entry
//            out_ready  downstream consumes this cycle
//            out_data   head payload, NOP_VALUE when out_valid=0
//            flush      synchronous kill of all held entries
//            stall_cnt  saturating count of out_valid && !out_ready cycles
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_stage_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_accept;
  logic             w_pop;

  assign out_valid = (r_state != EMPTY);
  assign out_data  = out_valid ? r_main : NOP_VALUE;
  assign stall_cnt = r_stall_cnt;

  // A flushed cycle's input is dropped, so it never counts as accepted.
  assign w_accept = in_valid && in_ready && !flush;
  assign w_pop    = out_valid && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: if (w_accept) w_state_nxt = ONE;
        ONE: begin
          if (w_accept && !w_pop) begin
`ifdef PIPE_STAGE_SKID_EN
            w_state_nxt = TWO;
`else
            // Unreachable: single-register in_ready requires a pop.
            w_state_nxt = ONE;
`endif
          end else if (!w_accept && w_pop) begin
            w_state_nxt = EMPTY;
          end
        end
        TWO:     if (w_pop) w_state_nxt = ONE;
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  logic [WIDTH-1:0] r_skid;
  logic             r_in_ready;

  assign in_ready = r_in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main     <= NOP_VALUE;
      r_skid     <= NOP_VALUE;
      r_in_ready <= 1'b0;
    end else begin
      r_in_ready <= (w_state_nxt != TWO);
      if (flush) begin
        r_main <= NOP_VALUE;
        r_skid <= NOP_VALUE;
      end else begin
        case (r_state)
          EMPTY: if (w_accept) r_main <= in_data;
          ONE: begin
            if (w_accept && w_pop) r_main <= in_data;
            else if (w_accept)     r_skid <= in_data;
          end
          TWO:     if (w_pop) r_main <= r_skid;
          default: r_main <= NOP_VALUE;
        endcase
      end
    end
  end
`else
  // r_live holds in_ready low until the first edge after reset release.
  logic r_live;

  assign in_ready = rst && r_live && (!out_valid || out_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main <= NOP_VALUE;
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (flush) begin
        r_main <= NOP_VALUE;
      end else if (w_accept) begin
        r_main <= in_data;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
//------------------------------------------------------------------------------
// Module   : tb_pipe_stage_reg
// Purpose  : Self-checking bench for pipe_stage_reg. Two instances share the
//            stimulus: a default one (WIDTH=32, NOP=0, CNT_W=16) and a narrow
//            one (WIDTH=8, NOP=0xEE, CNT_W=2). Both are compared each cycle
//            against a queue-based model of the stage.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_stage_reg;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        flush;

  logic        a_in_ready, a_out_valid;
  logic [31:0] a_out_data;
  logic [15:0] a_stall;

  logic        b_in_ready, b_out_valid;
  logic [7:0]  b_out_data;
  logic [1:0]  b_stall;
  logic [7:0]  b_in_data;

  assign b_in_data = in_data[7:0];

  pipe_stage_reg #(.WIDTH(32), .NOP_VALUE(32'h0), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .flush(flush), .stall_cnt(a_stall)
  );

  pipe_stage_reg #(.WIDTH(8), .NOP_VALUE(8'hEE), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .flush(flush), .stall_cnt(b_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue of held entries and stall totals.
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  logic [31:0] q[$];
  bit          live;
  int unsigned stall_a;
  int unsigned stall_b;

  int n_total;
  int n_bad;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_ready(input bit ordy);
    if (!live) return 1'b0;
    if (CAP == 2) return (q.size() < 2);
    return (q.size() == 0) || ordy;
  endfunction

  // One clock cycle: apply inputs, check outputs at negedge, advance model at posedge.
  task automatic cyc(input bit v, input logic [31:0] d, input bit ordy, input bit fl);
    bit          er;
    bit          ev;
    logic [31:0] head;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    er   = model_ready(ordy);
    ev   = (q.size() > 0);
    head = ev ? q[0] : 32'h0;
    chk("a_in_ready",  {63'b0, a_in_ready},  {63'b0, er});
    chk("a_out_valid", {63'b0, a_out_valid}, {63'b0, ev});
    chk("a_out_data",  {32'b0, a_out_data},  {32'b0, head});
    chk("a_stall_cnt", {48'b0, a_stall},     64'(stall_a));
    chk("b_in_ready",  {63'b0, b_in_ready},  {63'b0, er});
    chk("b_out_valid", {63'b0, b_out_valid}, {63'b0, ev});
    chk("b_out_data",  {56'b0, b_out_data},  ev ? {56'b0, head[7:0]} : 64'hEE);
    chk("b_stall_cnt", {62'b0, b_stall},     64'(stall_b));
    @(posedge clk);
    if (ev && !ordy) begin
      if (stall_a < 65535) stall_a++;
      if (stall_b < 3)     stall_b++;
    end
    if (fl) begin
      q.delete();
    end else begin
      if (ev && ordy) void'(q.pop_front());
      if (v && er)    q.push_back(d);
    end
    live = 1'b1;
    #1;
  endtask

  // Reset asserted and released between clock edges.
  task automatic mid_reset();
    #2;
    rst = 1'b0;
    #1;
    chk("rst_a_valid", {63'b0, a_out_valid}, 64'h0);
    chk("rst_a_data",  {32'b0, a_out_data},  64'h0);
    chk("rst_a_ready", {63'b0, a_in_ready},  64'h0);
    chk("rst_a_stall", {48'b0, a_stall},     64'h0);
    chk("rst_b_data",  {56'b0, b_out_data},  64'hEE);
    chk("rst_b_ready", {63'b0, b_in_ready},  64'h0);
    q.delete();
    live    = 1'b0;
    stall_a = 0;
    stall_b = 0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rel_a_ready", {63'b0, a_in_ready}, 64'h0);
    chk("rel_b_ready", {63'b0, b_in_ready}, 64'h0);
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    live      = 1'b0;
    stall_a   = 0;
    stall_b   = 0;

    #3;
    chk("init_a_valid", {63'b0, a_out_valid}, 64'h0);
    chk("init_a_data",  {32'b0, a_out_data},  64'h0);
    chk("init_b_data",  {56'b0, b_out_data},  64'hEE);
    chk("init_a_ready", {63'b0, a_in_ready},  64'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("first_a_ready", {63'b0, a_in_ready}, 64'h0);

    // Single transfer, then bubble.
    cyc(0, 32'h0, 1, 0);
    cyc(1, 32'h11, 1, 0);
    cyc(0, 32'h0, 1, 0);
    cyc(0, 32'h0, 1, 0);

    // Back-to-back stream.
    for (int i = 1; i <= 8; i++) cyc(1, 32'(i), 1, 0);
    cyc(0, 32'h0, 1, 0);
    cyc(0, 32'h0, 1, 0);

    // Load under backpressure, then drain.
    cyc(1, 32'hA, 0, 0);
    cyc(1, 32'hB, 0, 0);
    cyc(1, 32'hB, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 32'h0, 1, 0);

    // Flush while full with a competing input.
    cyc(1, 32'hA, 0, 0);
    cyc(1, 32'hB, 0, 0);
    cyc(1, 32'hC, 0, 1);
    cyc(0, 32'h0, 1, 0);
    cyc(0, 32'h0, 1, 0);

    // Stall counting and saturation from a clean reset.
    mid_reset();
    cyc(0, 32'h0, 1, 0);
    cyc(1, 32'hAB, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 32'h0, 0, 0);
    chk("stall_a_5", {48'b0, a_stall}, 64'd5);
    chk("stall_b_5", {62'b0, b_stall}, 64'd3);
    for (int i = 0; i < 5; i++) cyc(0, 32'h0, 0, 0);
    chk("stall_a_10", {48'b0, a_stall}, 64'd10);
    cyc(0, 32'h0, 1, 1);
    chk("stall_flush", {48'b0, a_stall}, 64'd10);

    // Reset while holding one entry.
    cyc(1, 32'h55, 1, 0);
    mid_reset();
    cyc(0, 32'h0, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0, ($urandom % 25) == 0);
      if ((i % 300) == 299) mid_reset();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits (1..512).
REQ-002 Parameter NOP_VALUE, default 0 (WIDTH bits), payload presented when stage holds a bubble.
REQ-003 Parameter CNT_W, default 16, stall-counter width.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 in_valid  input  1  upstream holds a valid entry.
REQ-007 in_ready  output  1  stage accepts this cycle; transfer when in_valid && in_ready.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 out_valid  output  1  stage presents a valid entry.
REQ-010 out_ready  input  1  downstream consumes; pop when out_valid && out_ready.
REQ-011 out_data  output  WIDTH  head payload; NOP_VALUE whenever out_valid=0.
REQ-012 flush  input  1  synchronous kill of all held entries.
REQ-013 stall_cnt  output  CNT_W  saturating count of backpressure cycles.

Function
REQ-014 Latency in->out exactly 1 cycle when empty; sustained throughput 1 entry/cycle with out_ready=1.
REQ-015 Order preserved; no entry duplicated or lost except via flush.
REQ-016 States EMPTY (0 entries), ONE (main reg valid), TWO (main + skid valid; skid build only).
REQ-017 EMPTY: accept -> ONE, main<=in_data; else EMPTY.
REQ-018 ONE: accept&pop -> ONE, main<=in_data; accept&!pop -> TWO, skid<=in_data; !accept&pop -> EMPTY; else ONE.
REQ-019 TWO: pop -> ONE, main<=skid; else TWO; no accept in TWO.
REQ-020 out_valid=1 in ONE/TWO; out_data=main in ONE/TWO, NOP_VALUE in EMPTY.
REQ-021 flush=1: next state EMPTY regardless of in_valid/out_ready; same-cycle input discarded; same-cycle pop still counts as consumed downstream.
REQ-022 stall_cnt increments by 1 each cycle with out_valid=1 && out_ready=0; holds at all-ones; not cleared by flush.
REQ-023 Upstream must hold in_data stable while in_valid=1 && in_ready=0; stage does not check.

Reset
REQ-024 rst=0 asynchronously forces: state EMPTY, out_valid=0, out_data=NOP_VALUE, in_ready=0, stall_cnt=0, main/skid=NOP_VALUE.
REQ-025 in_ready rises no earlier than the first rising clk edge after rst deasserts; no transfer occurs while rst=0.
REQ-026 Reset mid-operation discards all entries with no partial output.

Configuration
REQ-027 Macro PIPE_STAGE_SKID_EN defined: two-entry skid; in_ready is a flop, next value = (next state != TWO) && rst deasserted; no combinational path out_ready->in_ready.
REQ-028 Macro undefined: single register, states EMPTY/ONE only; in_ready = rst && (!out_valid || out_ready) combinationally; TWO unreachable; all other REQs hold.

Verification
REQ-029 Reset then in_valid=1, in_data=0x11, out_ready=1 -> next cycle out_valid=1, out_data=0x11; following cycle out_data=NOP_VALUE if no new input.
REQ-030 Stream 0x01..0x08 back-to-back, out_ready=1 -> out_data 0x01..0x08 on 8 consecutive cycles, 1-cycle offset.
REQ-031 Skid build: load 0xA, 0xB with out_ready=0 -> in_ready=0 after 2nd accept; raise out_ready -> 0xA then 0xB, in_ready=1 again; no loss.
REQ-032 Hold out_ready=0 with valid entry for 5 cycles -> stall_cnt=5; with CNT_W=2 run 10 cycles -> stall_cnt=3.
REQ-033 flush=1 in TWO with in_valid=1, in_data=0xC -> next cycle out_valid=0, out_data=NOP_VALUE; 0xC never appears.
REQ-034 Assert rst=0 between edges while in ONE -> out_valid=0, out_data=NOP_VALUE immediately, in_ready=0 until first edge after release.
